// File: rtl/button_event_scheduler_pkg.sv
// Shared definitions for the button event scheduler: pulser state encodings
// and the default number of button channels.
package button_event_scheduler_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      PS_IDLE  = 2'b00,
      PS_PULSE = 2'b01,
      PS_HOLD  = 2'b10
   } ps_e;

endpackage

// File: rtl/button_event_scheduler_edge_pulser.sv
// Per-button edge pulser: emits exactly one cycle of sp per press of a
// synchronised level input, then waits for release before re-arming.
module edge_pulser
   import button_event_scheduler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic lp,
   output logic sp
);

   ps_e state_q;
   ps_e state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sp      = 1'b0;
      case (state_q)
         PS_IDLE: begin
            if (lp) state_d = PS_PULSE;
         end
         PS_PULSE: begin
            sp      = 1'b1;
            state_d = PS_HOLD;
         end
         PS_HOLD: begin
            if (!lp) state_d = PS_IDLE;
         end
         default: state_d = PS_IDLE;
      endcase
   end

endmodule

// File: rtl/button_event_scheduler.sv
// Converts N button levels into one-shot events and serialises them onto a
// single valid/ready channel with round-robin fairness between buttons.
module button_event_scheduler
   import button_event_scheduler_pkg::*;
#(
   parameter  int N   = N_DEFAULT,
   localparam int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   lp,
   output logic           ev_valid,
   output logic [IDW-1:0] ev_id,
   input  logic           ev_ready,
   output logic [N-1:0]   pending,
   output logic [N-1:0]   ovf,
   input  logic           ovf_clr
);

   // Handshake: an event transfers on any posedge where ev_valid && ev_ready;
   // while ev_valid && !ev_ready, ev_valid and ev_id are held unchanged.

   logic [N-1:0]   pulse;
   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   ovf_q, ovf_d;
   logic [N-1:0]   grant_mask;
   logic [IDW-1:0] rr_q, rr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [IDW-1:0] winner;
   logic           valid_q, valid_d;
   logic           any_pending;
   logic           load;

   for (genvar g = 0; g < N; g++) begin : g_pulser
      edge_pulser u_pulser (
         .clk (clk),
         .rst (rst),
         .lp  (lp[g]),
         .sp  (pulse[g])
      );
   end

   // Walk the search order backwards so the last hit is the closest to rr_q+1.
   always_comb begin
      winner = '0;
      for (int k = N; k >= 1; k--) begin
         if (pending_q[(int'(rr_q) + k) % N]) begin
            winner = IDW'((int'(rr_q) + k) % N);
         end
      end
   end

   always_comb begin
      any_pending = |pending_q;
      load        = !valid_q || ev_ready;
      grant_mask  = (load && any_pending) ? (N'(1) << winner) : '0;
      // A pulse landing on a channel being loaded this cycle is a new event.
      pending_d   = pulse | (pending_q & ~grant_mask);
      ovf_d       = ovf_clr ? '0 : (ovf_q | (pulse & pending_q & ~grant_mask));
      valid_d     = load ? any_pending : valid_q;
      id_d        = (load && any_pending) ? winner : id_q;
      rr_d        = (load && any_pending) ? winner : rr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         ovf_q     <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         rr_q      <= IDW'(N - 1);
      end else begin
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         rr_q      <= rr_d;
      end
   end

   assign ev_valid = valid_q;
   assign ev_id    = id_q;
   assign pending  = pending_q;
   assign ovf      = ovf_q;

endmodule
